parking_quota_controller: RTL and testbench

Parametrised two-class (reserved/general) parking occupancy controller with an hourly quota schedule, a registered request/acknowledge interface for gates, and over-quota tracking. Total capacity is shared between the classes. The general quota grows on a programmable afternoon schedule and resets at day start. Sits between the gate sensor front-end and the display/billing logic.

---
 rtl/parking_quota_controller_if.sv | 15 +
 rtl/parking_quota_controller.sv | 83 ++++++++
 tb/tb_parking_quota_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/parking_quota_controller_if.sv
// parking_quota_controller_if: gate request/acknowledge bundle between the gate front-end and the controller
interface parking_quota_controller_if;
    logic entry_req;
    logic entry_class;
    logic exit_req;
    logic exit_class;
    logic entry_ack;
    logic entry_nack;
    logic exit_ack;
    logic exit_err;
    modport master (output entry_req, entry_class, exit_req, exit_class,
                    input entry_ack, entry_nack, exit_ack, exit_err);
    modport slave (input entry_req, entry_class, exit_req, exit_class,
                   output entry_ack, entry_nack, exit_ack, exit_err);
endinterface

// File: rtl/parking_quota_controller.sv
// parking_quota_controller: two-class parking occupancy with hourly general-quota schedule and gate acks
module parking_quota_controller #(
    parameter int CNT_W          = 10,
    parameter int TOTAL_CAP      = 700,
    parameter int GEN_BASE       = 200,
    parameter int TICKS_PER_HOUR = 3600,
    parameter int DAY_START_HOUR = 8,
    parameter int REL_START_HOUR = 13,
    parameter int REL_STEPS      = 3,
    parameter int REL_STEP       = 50,
    parameter int FINAL_STEP     = 150,
    parameter int DEN_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    parking_quota_controller_if.slave gate,
    output logic [CNT_W-1:0]     res_occ,
    output logic [CNT_W-1:0]     gen_occ,
    output logic [CNT_W-1:0]     res_free,
    output logic [CNT_W-1:0]     gen_free,
    output logic                 res_avail,
    output logic                 gen_avail,
    output logic                 res_over,
    output logic                 gen_over,
    output logic [4:0]           hour,
    output logic [DEN_W-1:0]     denied_cnt
);
    localparam int TW = TICKS_PER_HOUR > 1 ? $clog2(TICKS_PER_HOUR) : 1;
    logic [TW-1:0]    tick;
    logic [CNT_W-1:0] gen_quota, res_quota, gen_quota_nx, res_occ_nx, gen_occ_nx;
    logic [CNT_W:0]   quota_sum, quota_add;
    logic [4:0]       hour_nx;
    logic             hour_wrap, grant, exit_ok;
    always_comb begin
        res_quota    = CNT_W'(TOTAL_CAP) - gen_quota;
        res_free     = res_occ < res_quota ? res_quota - res_occ : '0;
        gen_free     = gen_occ < gen_quota ? gen_quota - gen_occ : '0;
        res_avail    = res_free != '0;
        gen_avail    = gen_free != '0;
        res_over     = res_occ > res_quota;
        gen_over     = gen_occ > gen_quota;
        hour_wrap    = tick_en && tick == TW'(TICKS_PER_HOUR - 1);
        hour_nx      = hour == 5'd23 ? 5'd0 : hour + 5'd1;
        quota_add    = (hour_nx >= 5'(REL_START_HOUR) && hour_nx <= 5'(REL_START_HOUR + REL_STEPS - 1)) ? (CNT_W+1)'(REL_STEP) :
                       hour_nx == 5'(REL_START_HOUR + REL_STEPS) ? (CNT_W+1)'(FINAL_STEP) : '0;
        quota_sum    = {1'b0, gen_quota} + quota_add;
        gen_quota_nx = hour_nx == 5'(DAY_START_HOUR) ? CNT_W'(GEN_BASE) :
                       quota_sum > (CNT_W+1)'(TOTAL_CAP) ? CNT_W'(TOTAL_CAP) : quota_sum[CNT_W-1:0];
        // decisions use pre-edge free/occupancy, so a same-cycle exit never makes room for an entry
        grant        = gate.entry_req && (gate.entry_class ? res_avail : gen_avail);
        exit_ok      = gate.exit_req && (gate.exit_class ? res_occ != '0 : gen_occ != '0);
        res_occ_nx   = res_occ + CNT_W'(grant && gate.entry_class) - CNT_W'(exit_ok && gate.exit_class);
        gen_occ_nx   = gen_occ + CNT_W'(grant && !gate.entry_class) - CNT_W'(exit_ok && !gate.exit_class);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick            <= '0;
            hour            <= 5'(DAY_START_HOUR);
            gen_quota       <= CNT_W'(GEN_BASE);
            res_occ         <= '0;
            gen_occ         <= '0;
            gate.entry_ack  <= 1'b0;
            gate.entry_nack <= 1'b0;
            gate.exit_ack   <= 1'b0;
            gate.exit_err   <= 1'b0;
            denied_cnt      <= '0;
        end else begin
            if (tick_en) tick <= hour_wrap ? '0 : tick + TW'(1);
            if (hour_wrap) begin
                hour      <= hour_nx;
                gen_quota <= gen_quota_nx;
            end
            res_occ         <= res_occ_nx;
            gen_occ         <= gen_occ_nx;
            gate.entry_ack  <= grant;
            gate.entry_nack <= gate.entry_req && !grant;
            gate.exit_ack   <= exit_ok;
            gate.exit_err   <= gate.exit_req && !exit_ok;
            if (gate.entry_req && !grant && !(&denied_cnt)) denied_cnt <= denied_cnt + DEN_W'(1);
        end
    end
endmodule

// File: tb/tb_parking_quota_controller.sv
// tb_parking_quota_controller: directed vectors with a response scoreboard and status checks
module tb_parking_quota_controller;
    localparam logic [3:0] ACK = 4'b1000, NACK = 4'b0100, XACK = 4'b0010, XERR = 4'b0001;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_en = 1'b0;
    logic [9:0] res_occ, gen_occ, res_free, gen_free;
    logic res_avail, gen_avail, res_over, gen_over;
    logic [4:0] hour;
    logic [15:0] denied_cnt;
    logic [3:0] q[$];
    int checks = 0;
    int failures = 0;
    parking_quota_controller_if g();
    parking_quota_controller #(.TICKS_PER_HOUR(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .gate(g),
        .res_occ(res_occ), .gen_occ(gen_occ), .res_free(res_free), .gen_free(gen_free),
        .res_avail(res_avail), .gen_avail(gen_avail), .res_over(res_over), .gen_over(gen_over),
        .hour(hour), .denied_cnt(denied_cnt)
    );
    always #5 clk = ~clk;
    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", n, act, exp);
        end
    endfunction
    always @(negedge clk) begin
        logic [3:0] r;
        r = {g.entry_ack, g.entry_nack, g.exit_ack, g.exit_err};
        if (rst_n && r != 4'b0) begin
            if (q.size() == 0) chk("unexpected_resp", int'(r), 0);
            else chk("resp", int'(r), int'(q.pop_front()));
        end
    end
    task automatic cyc(input logic en, ec, xr, xc, tk, input logic [3:0] e);
        @(negedge clk);
        g.entry_req = en; g.entry_class = ec; g.exit_req = xr; g.exit_class = xc; tick_en = tk;
        if (en || xr) q.push_back(e);
    endtask
    task automatic quiet();
        @(negedge clk);
        g.entry_req = 0; g.entry_class = 0; g.exit_req = 0; g.exit_class = 0; tick_en = 0;
    endtask
    task automatic ticks(input int n);
        repeat (n) cyc(0, 0, 0, 0, 1, 4'b0);
        quiet();
    endtask
    initial begin
        g.entry_req = 0; g.entry_class = 0; g.exit_req = 0; g.exit_class = 0;
        @(negedge clk);
        chk("rst_gen_occ", gen_occ, 0);
        chk("rst_gen_free", gen_free, 200);
        chk("rst_res_free", res_free, 500);
        chk("rst_hour", hour, 8);
        chk("rst_acks", {g.entry_ack, g.entry_nack, g.exit_ack, g.exit_err}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (37) cyc(1, 0, 0, 0, 0, ACK);
        quiet();
        chk("mid_gen_occ", gen_occ, 37);
        chk("mid_gen_free", gen_free, 163);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gen_occ", gen_occ, 0);
        chk("async_gen_free", gen_free, 200);
        chk("async_res_free", res_free, 500);
        chk("async_hour", hour, 8);
        chk("async_denied", denied_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (200) cyc(1, 0, 0, 0, 0, ACK);
        quiet();
        chk("fill_gen_occ", gen_occ, 200);
        chk("fill_gen_free", gen_free, 0);
        chk("fill_gen_avail", gen_avail, 0);
        cyc(1, 0, 0, 0, 0, NACK);
        quiet();
        chk("full_denied", denied_cnt, 1);
        chk("full_gen_occ", gen_occ, 200);
        cyc(1, 0, 1, 0, 0, NACK | XACK);
        quiet();
        chk("simul_gen_occ", gen_occ, 199);
        chk("simul_denied", denied_cnt, 2);
        cyc(1, 0, 0, 0, 0, ACK);
        quiet();
        chk("refill_gen_occ", gen_occ, 200);
        cyc(0, 0, 1, 1, 0, XERR);
        quiet();
        chk("err_res_occ", res_occ, 0);
        repeat (19) cyc(0, 0, 0, 0, 1, 4'b0);
        cyc(1, 0, 0, 0, 1, NACK);
        quiet();
        chk("h13_hour", hour, 13);
        chk("h13_gen_free", gen_free, 50);
        chk("h13_res_free", res_free, 450);
        chk("h13_denied", denied_cnt, 3);
        repeat (300) cyc(1, 1, 0, 0, 0, ACK);
        quiet();
        chk("park_res_free", res_free, 150);
        ticks(4);
        chk("h14_gen_free", gen_free, 100);
        ticks(4);
        chk("h15_res_free", res_free, 50);
        ticks(4);
        chk("h16_hour", hour, 16);
        chk("h16_gen_free", gen_free, 300);
        chk("h16_res_free", res_free, 0);
        chk("h16_res_over", res_over, 1);
        chk("h16_res_avail", res_avail, 0);
        chk("h16_res_occ", res_occ, 300);
        cyc(1, 1, 0, 0, 0, NACK);
        quiet();
        chk("over_denied", denied_cnt, 4);
        repeat (100) cyc(0, 0, 1, 1, 0, XACK);
        quiet();
        chk("drain_res_occ", res_occ, 200);
        chk("drain_res_over", res_over, 0);
        chk("drain_res_free", res_free, 0);
        cyc(0, 0, 1, 1, 0, XACK);
        quiet();
        chk("drain1_res_free", res_free, 1);
        chk("drain1_res_avail", res_avail, 1);
        repeat (100) cyc(1, 0, 0, 0, 0, ACK);
        quiet();
        chk("h16_gen_fill", gen_free, 200);
        ticks(64);
        chk("day_hour", hour, 8);
        chk("day_gen_over", gen_over, 1);
        chk("day_gen_free", gen_free, 0);
        chk("day_res_free", res_free, 301);
        cyc(1, 0, 0, 0, 0, NACK);
        cyc(1, 1, 0, 0, 0, ACK);
        quiet();
        chk("day_denied", denied_cnt, 5);
        chk("day_res_occ", res_occ, 200);
        chk("day_gen_occ", gen_occ, 300);
        repeat (3) quiet();
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
